// File: rtl/aes_pkg.sv
// Shared AES definitions used by the round-key buffer and its sub-blocks.
//   AES_KEY_W / AES128_NR : default round-key width and round count (AES-128)
//   aes_idx_t             : round index type
//   aes_rkey_t            : round key type
//   aes_kb_state_e        : key-buffer FSM states (WIPE is only reachable when
//                           AES_KEYBUF_ZEROIZE_EN is defined)
package aes_pkg;

    localparam int AES_KEY_W = 128;
    localparam int AES128_NR = 10;

    typedef logic [3:0]           aes_idx_t;
    typedef logic [AES_KEY_W-1:0] aes_rkey_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2,
        WIPE  = 2'd3
    } aes_kb_state_e;

endpackage

// File: rtl/aes_round_key_buffer_if.sv
// Bus bundle for aes_round_key_buffer.
//   Fill side : start, short_key, subkey, valid_skey (from the key expander)
//   Read side : rd_en, rd_idx, rd_rev -> rd_data, rd_valid, rd_err
//   Status    : keys_ready, fill_err, fill_cnt
//   Optional  : zeroize (only with AES_KEYBUF_ZEROIZE_EN defined)
// master = the side driving fill/read requests, slave = the key buffer.
interface aes_round_key_buffer_if #(
    parameter int KEY_W = 128,
    parameter int IDX_W = 4
);
    logic             start;
    logic [KEY_W-1:0] short_key;
    logic [KEY_W-1:0] subkey;
    logic             valid_skey;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_rev;
    logic [KEY_W-1:0] rd_data;
    logic             rd_valid;
    logic             rd_err;
    logic             keys_ready;
    logic             fill_err;
    logic [IDX_W-1:0] fill_cnt;
`ifdef AES_KEYBUF_ZEROIZE_EN
    logic             zeroize;

    modport master (
        output start, short_key, subkey, valid_skey, rd_en, rd_idx, rd_rev, zeroize,
        input  rd_data, rd_valid, rd_err, keys_ready, fill_err, fill_cnt
    );
    modport slave (
        input  start, short_key, subkey, valid_skey, rd_en, rd_idx, rd_rev, zeroize,
        output rd_data, rd_valid, rd_err, keys_ready, fill_err, fill_cnt
    );
`else
    modport master (
        output start, short_key, subkey, valid_skey, rd_en, rd_idx, rd_rev,
        input  rd_data, rd_valid, rd_err, keys_ready, fill_err, fill_cnt
    );
    modport slave (
        input  start, short_key, subkey, valid_skey, rd_en, rd_idx, rd_rev,
        output rd_data, rd_valid, rd_err, keys_ready, fill_err, fill_cnt
    );
`endif
endinterface

// File: rtl/aes_key_store.sv
// Round-key storage: DEPTH x KEY_W register array, one write port and one
// registered read port.
//   clk, reset : clock, async active-high reset (read register only)
//   we/waddr/wdata : synchronous write
//   re/raddr   : load rdata from entry raddr on the next edge
//   rclr       : force rdata to 0 on the next edge (wins over re)
//   rdata      : registered read data; holds when neither re nor rclr
// The array itself has no reset so it can map onto distributed RAM with the
// output register absorbed into the read path.
module aes_key_store #(
    parameter int DEPTH = 11,
    parameter int KEY_W = 128,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [KEY_W-1:0] wdata,
    input  logic             re,
    input  logic             rclr,
    input  logic [AW-1:0]    raddr,
    output logic [KEY_W-1:0] rdata
);

    logic [KEY_W-1:0] mem_q [DEPTH];
    logic [KEY_W-1:0] rdata_d, rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rclr)    rdata_d = '0;
        else if (re) rdata_d = mem_q[raddr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdata_q <= '0;
        else       rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/aes_round_key_buffer.sv
// AES round-key buffer. Captures the cipher key on start and the NR following
// subkeys from the key expander, then serves them by index to the round
// datapath, in forward order (encrypt) or mirrored order NR-idx (decrypt).
// A stream that stalls for TIMEOUT consecutive cycles aborts the fill and
// raises the sticky fill_err.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : aes_round_key_buffer_if.slave (fill stream, read port, status)
// Optional feature macro: AES_KEYBUF_ZEROIZE_EN adds bus.zeroize and a WIPE
// state that clears every entry, one per cycle, before returning to IDLE.
// IDX_W must be wide enough that 2^IDX_W > NR.
module aes_round_key_buffer
    import aes_pkg::*;
#(
    parameter int NR      = AES128_NR,
    parameter int KEY_W   = AES_KEY_W,
    parameter int IDX_W   = 4,
    parameter int TIMEOUT = 4
) (
    input  logic                clk,
    input  logic                reset,
    aes_round_key_buffer_if.slave bus
);

    localparam int               TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NR);

    aes_kb_state_e    state_q, state_d;
    logic [IDX_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             fill_err_q, fill_err_d;
    logic             keys_ready_q, keys_ready_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_err_q, rd_err_d;

    logic             we;
    logic [IDX_W-1:0] waddr;
    logic [KEY_W-1:0] wdata;
    logic             rd_ok, rd_bad;
    logic [IDX_W-1:0] raddr;
`ifdef AES_KEYBUF_ZEROIZE_EN
    logic [IDX_W-1:0] wipe_idx_q, wipe_idx_d;
`endif

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        tmo_d      = tmo_q;
        fill_err_d = fill_err_q;
        we         = 1'b0;
        waddr      = fill_cnt_q;
        wdata      = bus.subkey;
`ifdef AES_KEYBUF_ZEROIZE_EN
        wipe_idx_d = wipe_idx_q;
`endif
        // start restarts the fill from any state except WIPE and beats any
        // subkey presented in the same cycle.
        if (bus.start && state_q != WIPE) begin
            we         = 1'b1;
            waddr      = '0;
            wdata      = bus.short_key;
            fill_cnt_d = IDX_W'(1);
            tmo_d      = '0;
            fill_err_d = 1'b0;
            state_d    = FILL;
        end else begin
            case (state_q)
                FILL: begin
                    if (bus.valid_skey) begin
                        we         = 1'b1;
                        fill_cnt_d = fill_cnt_q + IDX_W'(1);
                        tmo_d      = '0;
                        if (fill_cnt_q == LAST) state_d = READY;
                    end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        // This idle cycle makes TIMEOUT in a row: abort,
                        // keeping fill_cnt as evidence of how far it got.
                        fill_err_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end
`ifdef AES_KEYBUF_ZEROIZE_EN
                WIPE: begin
                    we         = 1'b1;
                    waddr      = wipe_idx_q;
                    wdata      = '0;
                    wipe_idx_d = wipe_idx_q + IDX_W'(1);
                    if (wipe_idx_q == LAST) begin
                        state_d    = IDLE;
                        fill_cnt_d = '0;
                    end
                end
`endif
                default: ;
            endcase
        end
`ifdef AES_KEYBUF_ZEROIZE_EN
        // zeroize overrides everything, including an in-progress wipe.
        if (bus.zeroize) begin
            we         = 1'b0;
            state_d    = WIPE;
            wipe_idx_d = '0;
            fill_cnt_d = '0;
        end
`endif
        keys_ready_d = (state_d == READY);

        // Read port is judged on the current (pre-start) state.
        rd_ok      = bus.rd_en && (state_q == READY) && (bus.rd_idx <= LAST);
        rd_bad     = bus.rd_en && !rd_ok;
        raddr      = bus.rd_rev ? (LAST - bus.rd_idx) : bus.rd_idx;
        rd_valid_d = rd_ok;
        rd_err_d   = rd_bad;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            fill_cnt_q   <= '0;
            tmo_q        <= '0;
            fill_err_q   <= 1'b0;
            keys_ready_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            tmo_q        <= tmo_d;
            fill_err_q   <= fill_err_d;
            keys_ready_q <= keys_ready_d;
            rd_valid_q   <= rd_valid_d;
            rd_err_q     <= rd_err_d;
        end
    end

`ifdef AES_KEYBUF_ZEROIZE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wipe_idx_q <= '0;
        else       wipe_idx_q <= wipe_idx_d;
    end
`endif

    // Refused reads clear the output register so no stale key is exposed.
    aes_key_store #(
        .DEPTH(NR + 1),
        .KEY_W(KEY_W),
        .AW   (IDX_W)
    ) u_store (
        .clk  (clk),
        .reset(reset),
        .we   (we),
        .waddr(waddr),
        .wdata(wdata),
        .re   (rd_ok),
        .rclr (rd_bad),
        .raddr(raddr),
        .rdata(bus.rd_data)
    );

    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_err     = rd_err_q;
    assign bus.keys_ready = keys_ready_q;
    assign bus.fill_err   = fill_err_q;
    assign bus.fill_cnt   = fill_cnt_q;

endmodule

// File: tb/tb_aes_round_key_buffer.sv
module tb_aes_round_key_buffer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    aes_round_key_buffer_if #(.KEY_W(128), .IDX_W(4)) bus ();

    aes_round_key_buffer dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic         valid;
        logic         err;
        logic [127:0] data;
    } exp_t;

    typedef struct {
        logic       en;
        logic [3:0] idx;
        logic       rev;
        logic       ok;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;
    exp_t sb[$];
    logic [127:0] model [11];
    logic [127:0] rk_a  [11];
    logic [127:0] rk_b  [11];
    logic [127:0] stream[11];
    logic [127:0] last_data = '0;
    vec_t tbl[12];

    function automatic void check(string nm, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Drive one read request and push the expected response.
    task automatic rd_issue(input logic en, input logic [3:0] idx, input logic rev, input logic ok);
        exp_t e;
        bus.rd_en  = en;
        bus.rd_idx = idx;
        bus.rd_rev = rev;
        if (!en)     e = '{1'b0, 1'b0, last_data};
        else if (ok) e = '{1'b1, 1'b0, model[rev ? 4'd10 - idx : idx]};
        else         e = '{1'b0, 1'b1, 128'd0};
        last_data = e.data;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rd_valid", {127'd0, bus.rd_valid}, {127'd0, e.valid});
            check("rd_err",   {127'd0, bus.rd_err},   {127'd0, e.err});
            check("rd_data",  bus.rd_data, e.data);
        end
        bus.rd_en = 1'b0;
    endtask

    task automatic feed(input int first);
        for (int i = first; i <= 10; i++) begin
            bus.valid_skey = 1'b1;
            bus.subkey     = stream[i];
            tick();
            check("keys_ready_fill", {127'd0, bus.keys_ready}, {127'd0, (i == 10)});
        end
        // Extra subkey after entry NR must be ignored.
        bus.subkey = ~stream[10];
        tick();
        bus.valid_skey = 1'b0;
        check("fill_cnt_full", {124'd0, bus.fill_cnt}, 128'd11);
        for (int i = 0; i <= 10; i++) model[i] = stream[i];
    endtask

    task automatic fill_run();
        bus.start      = 1'b1;
        bus.short_key  = stream[0];
        bus.valid_skey = 1'b1;          // must be ignored in the start cycle
        bus.subkey     = ~stream[1];
        tick();
        bus.start = 1'b0;
        check("fill_cnt_start", {124'd0, bus.fill_cnt}, 128'd1);
        feed(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rk_a[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i <= 10; i++) rk_b[i] = {16{8'(8'h40 + i)}};
        for (int i = 0; i <= 10; i++) model[i] = '0;

        //            en    idx    rev   ok
        tbl[0]  = '{1'b1, 4'd0,  1'b0, 1'b1};
        tbl[1]  = '{1'b1, 4'd1,  1'b0, 1'b1};
        tbl[2]  = '{1'b1, 4'd10, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 4'd0,  1'b1, 1'b1};
        tbl[4]  = '{1'b1, 4'd10, 1'b1, 1'b1};
        tbl[5]  = '{1'b1, 4'd3,  1'b1, 1'b1};
        tbl[6]  = '{1'b0, 4'd7,  1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'd11, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'd2,  1'b0, 1'b0};
        tbl[9]  = '{1'b1, 4'd15, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 4'd5,  1'b0, 1'b1};
        tbl[11] = '{1'b1, 4'd11, 1'b1, 1'b0};

        bus.start = 1'b0; bus.short_key = '0; bus.subkey = '0; bus.valid_skey = 1'b0;
        bus.rd_en = 1'b0; bus.rd_idx = '0; bus.rd_rev = 1'b0;
`ifdef AES_KEYBUF_ZEROIZE_EN
        bus.zeroize = 1'b0;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rd_data",    bus.rd_data, 128'd0);
        check("rst_rd_valid",   {127'd0, bus.rd_valid},   128'd0);
        check("rst_rd_err",     {127'd0, bus.rd_err},     128'd0);
        check("rst_keys_ready", {127'd0, bus.keys_ready}, 128'd0);
        check("rst_fill_err",   {127'd0, bus.fill_err},   128'd0);
        check("rst_fill_cnt",   {124'd0, bus.fill_cnt},   128'd0);
        reset = 1'b0;

        // Read in IDLE is refused
        rd_issue(1'b1, 4'd0, 1'b0, 1'b0);
        tick();

        // Normal fill with the FIPS-197 key, then table-driven back-to-back reads
        for (int i = 0; i <= 10; i++) stream[i] = rk_a[i];
        fill_run();
        for (int i = 0; i < 12; i++) begin
            rd_issue(tbl[i].en, tbl[i].idx, tbl[i].rev, tbl[i].ok);
            tick();
        end

        // Stall: 4 subkeys then 4 idle cycles -> fill_err, IDLE, fill_cnt=5
        bus.start = 1'b1; bus.short_key = rk_b[0];
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            bus.valid_skey = 1'b1; bus.subkey = rk_b[i];
            tick();
        end
        bus.valid_skey = 1'b0;
        rd_issue(1'b1, 4'd2, 1'b0, 1'b0);    // read during FILL
        tick();
        tick();
        tick();
        check("stall_no_err_yet", {127'd0, bus.fill_err}, 128'd0);
        tick();
        check("stall_fill_err",   {127'd0, bus.fill_err},   128'd1);
        check("stall_fill_cnt",   {124'd0, bus.fill_cnt},   128'd5);
        check("stall_keys_ready", {127'd0, bus.keys_ready}, 128'd0);
        rd_issue(1'b1, 4'd0, 1'b0, 1'b0);    // IDLE after abort
        tick();
        bus.start = 1'b1; bus.short_key = rk_a[0];
        tick();
        bus.start = 1'b0;
        check("restart_clears_err", {127'd0, bus.fill_err}, 128'd0);

        // Refill A, then restart from READY with key B and a same-cycle read
        fill_run();
        for (int i = 0; i <= 10; i++) stream[i] = rk_b[i];
        bus.start = 1'b1; bus.short_key = rk_b[0];
        rd_issue(1'b1, 4'd0, 1'b0, 1'b1);    // still returns A's entry 0
        tick();
        bus.start = 1'b0;
        check("restart_keys_ready", {127'd0, bus.keys_ready}, 128'd0);
        feed(1);
        rd_issue(1'b1, 4'd0, 1'b0, 1'b1); tick();
        rd_issue(1'b1, 4'd0, 1'b1, 1'b1); tick();
        rd_issue(1'b1, 4'd7, 1'b0, 1'b1); tick();

        // Async reset between clock edges while filling
        bus.start = 1'b1; bus.short_key = rk_a[0];
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            bus.valid_skey = 1'b1; bus.subkey = rk_a[i];
            tick();
        end
        bus.valid_skey = 1'b0;
        rd_issue(1'b1, 4'd1, 1'b0, 1'b0);
        tick();
        #3 reset = 1'b1;
        #1;
        check("arst_fill_cnt",   {124'd0, bus.fill_cnt},   128'd0);
        check("arst_rd_err",     {127'd0, bus.rd_err},     128'd0);
        check("arst_rd_valid",   {127'd0, bus.rd_valid},   128'd0);
        check("arst_keys_ready", {127'd0, bus.keys_ready}, 128'd0);
        check("arst_rd_data",    bus.rd_data, 128'd0);
        #1 reset = 1'b0;
        last_data = '0;
        rd_issue(1'b1, 4'd0, 1'b0, 1'b0);
        tick();

`ifdef AES_KEYBUF_ZEROIZE_EN
        // Zeroize from READY: 11 wipe cycles, start ignored, reads refused
        for (int i = 0; i <= 10; i++) stream[i] = rk_a[i];
        fill_run();
        bus.zeroize = 1'b1;
        tick();
        bus.zeroize = 1'b0;
        for (int w = 0; w <= 10; w++) begin
            bus.start = (w == 3);
            bus.short_key = rk_b[0];
            rd_issue(1'b1, 4'(w), 1'b0, 1'b0);
            tick();
            check("wipe_keys_ready", {127'd0, bus.keys_ready}, 128'd0);
        end
        bus.start = 1'b0;
        check("wipe_fill_cnt", {124'd0, bus.fill_cnt}, 128'd0);
        rd_issue(1'b1, 4'd0, 1'b0, 1'b0);
        tick();
        bus.start = 1'b1; bus.short_key = rk_b[0];
        tick();
        bus.start = 1'b0;
        check("post_wipe_start", {124'd0, bus.fill_cnt}, 128'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
